// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial line in, parallel byte with strobe and error flags out
interface uart_rx_fsm_if #(
   parameter int DATA_BITS = 8
);
   logic                 Rx_in;
   logic [DATA_BITS-1:0] Rx_data;
   logic                 Rx_valid;
   logic                 Parity_err;
   logic                 Frame_err;
   logic                 Busy;
   modport master (
      input  Rx_in,
      output Rx_data, Rx_valid, Parity_err, Frame_err, Busy
   );
   modport slave (
      output Rx_in,
      input  Rx_data, Rx_valid, Parity_err, Frame_err, Busy
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receiver with mid-bit sampling, parity and stop checks
module uart_rx_fsm #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input logic          Baud_Clk,
   input logic          Reset,
   uart_rx_fsm_if.master rx
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t               state_q;
   logic [1:0]           sync_q;
   logic                 prev_q;
   logic [TW-1:0]        tick_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q;
   logic                 perr_q, perr_d;
   logic                 valid_q, par_err_q, frm_err_q, busy_q;
   logic                 rxs, tick_end;
   assign rxs      = sync_q[1];
   assign tick_end = tick_q == TICK_END;
   assign shift_d  = {rxs, shift_q[DATA_BITS-1:1]};
   assign perr_d   = (^shift_q) ^ rxs ^ PARITY_ODD;
   always_ff @(posedge Baud_Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         sync_q    <= 2'b11;
         prev_q    <= 1'b1;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx.Rx_in};
         prev_q  <= rxs;
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // a falling edge is required, so a stuck-low line never starts a frame
               if (prev_q && !rxs) begin
                  state_q <= START;
                  tick_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (tick_q == TICK_MID) begin
                  tick_q  <= '0;
                  bit_q   <= '0;
                  state_q <= rxs ? IDLE : DATA;
                  busy_q  <= !rxs;
               end else
                  tick_q <= tick_q + TW'(1);
            end
            DATA: begin
               if (tick_end) begin
                  tick_q  <= '0;
                  shift_q <= shift_d;
                  bit_q   <= bit_q + BW'(1);
                  if (bit_q == BIT_LAST)
                     state_q <= PARITY_EN ? PARITY : STOP;
               end else
                  tick_q <= tick_q + TW'(1);
            end
            PARITY: begin
               if (tick_end) begin
                  tick_q  <= '0;
                  perr_q  <= perr_d;
                  state_q <= STOP;
               end else
                  tick_q <= tick_q + TW'(1);
            end
            STOP: begin
               if (tick_end) begin
                  tick_q    <= '0;
                  data_q    <= shift_q;
                  frm_err_q <= ~rxs;
                  par_err_q <= PARITY_EN & perr_q;
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else
                  tick_q <= tick_q + TW'(1);
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
   assign rx.Rx_data    = data_q;
   assign rx.Rx_valid   = valid_q;
   assign rx.Parity_err = par_err_q;
   assign rx.Frame_err  = frm_err_q;
   assign rx.Busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames against hand-computed bytes, flags and strobe timing
module tb_uart_rx_fsm;
   localparam int OS = 16;
   logic clk, rst;
   int   checks, failures, cyc, vcnt, v_cyc_prev, v_cyc_last, start_cyc, v0;
   logic [7:0] v_data_prev, v_data_last;
   uart_rx_fsm_if #(.DATA_BITS(8)) rx ();
   uart_rx_fsm dut (.Baud_Clk(clk), .Reset(rst), .rx(rx));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      vcnt = 0;
      v_cyc_prev = 0;
      v_cyc_last = 0;
      v_data_prev = '0;
      v_data_last = '0;
   end
   always @(negedge clk) begin
      if (rx.Rx_valid) begin
         vcnt        <= vcnt + 1;
         v_cyc_prev  <= v_cyc_last;
         v_cyc_last  <= cyc;
         v_data_prev <= v_data_last;
         v_data_last <= rx.Rx_data;
      end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask
   task automatic drive_bit(input logic b);
      rx.Rx_in = b;
      repeat (OS) @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] d, input logic p, input logic s);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(s);
   endtask
   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      rx.Rx_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_data", 32'(rx.Rx_data), 32'h00);
      check("rst_valid", 32'(rx.Rx_valid), 0);
      check("rst_perr", 32'(rx.Parity_err), 0);
      check("rst_ferr", 32'(rx.Frame_err), 0);
      check("rst_busy", 32'(rx.Busy), 0);
      rst = 1'b0;
      drive_bit(1'b1);
      drive_bit(1'b1);
      // clean 0xA5, even parity 0
      v0 = vcnt;
      send(8'hA5, 1'b0, 1'b1);
      drive_bit(1'b1);
      check("a5_pulses", 32'(vcnt - v0), 1);
      check("a5_data", 32'(rx.Rx_data), 32'hA5);
      check("a5_perr", 32'(rx.Parity_err), 0);
      check("a5_ferr", 32'(rx.Frame_err), 0);
      check("a5_busy", 32'(rx.Busy), 0);
      check("a5_latency_172pm2", 32'((v_cyc_last - start_cyc) >= 170 && (v_cyc_last - start_cyc) <= 174), 1);
      // 0x3C with wrong parity, then clean 0x01
      send(8'h3C, 1'b1, 1'b1);
      drive_bit(1'b1);
      check("3c_data", 32'(rx.Rx_data), 32'h3C);
      check("3c_perr", 32'(rx.Parity_err), 1);
      check("3c_ferr", 32'(rx.Frame_err), 0);
      send(8'h01, 1'b1, 1'b1);
      drive_bit(1'b1);
      check("01_data", 32'(rx.Rx_data), 32'h01);
      check("01_perr", 32'(rx.Parity_err), 0);
      // 0xFF with bad stop, line then held low 40 bit times
      v0 = vcnt;
      send(8'hFF, 1'b0, 1'b0);
      repeat (40) drive_bit(1'b0);
      check("ff_pulses", 32'(vcnt - v0), 1);
      check("ff_data", 32'(rx.Rx_data), 32'hFF);
      check("ff_ferr", 32'(rx.Frame_err), 1);
      check("ff_perr", 32'(rx.Parity_err), 0);
      check("ff_busy_low", 32'(rx.Busy), 0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check("ff_no_restart", 32'(vcnt - v0), 1);
      send(8'h0F, 1'b0, 1'b1);
      drive_bit(1'b1);
      check("0f_pulses", 32'(vcnt - v0), 2);
      check("0f_data", 32'(rx.Rx_data), 32'h0F);
      check("0f_ferr", 32'(rx.Frame_err), 0);
      // 4-cycle glitch
      v0 = vcnt;
      @(posedge clk);
      #1;
      rx.Rx_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx.Rx_in = 1'b1;
      check("glitch_busy_high", 32'(rx.Busy), 1);
      repeat (20) @(posedge clk);
      #1;
      check("glitch_busy_low", 32'(rx.Busy), 0);
      check("glitch_no_valid", 32'(vcnt - v0), 0);
      check("glitch_data_kept", 32'(rx.Rx_data), 32'h0F);
      // reset during bit 3 of 0x55
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rx.Rx_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      rx.Rx_in = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mrst_data", 32'(rx.Rx_data), 32'h00);
      check("mrst_busy", 32'(rx.Busy), 0);
      check("mrst_valid", 32'(rx.Rx_valid), 0);
      check("mrst_perr", 32'(rx.Parity_err), 0);
      check("mrst_ferr", 32'(rx.Frame_err), 0);
      repeat (3) drive_bit(1'b1);
      check("mrst_no_valid", 32'(vcnt - v0), 0);
      send(8'h81, 1'b0, 1'b1);
      drive_bit(1'b1);
      check("81_pulses", 32'(vcnt - v0), 1);
      check("81_data", 32'(rx.Rx_data), 32'h81);
      check("81_perr", 32'(rx.Parity_err), 0);
      // back-to-back 0x00 and 0xFF
      v0 = vcnt;
      send(8'h00, 1'b0, 1'b1);
      send(8'hFF, 1'b0, 1'b1);
      drive_bit(1'b1);
      check("b2b_pulses", 32'(vcnt - v0), 2);
      check("b2b_first", 32'(v_data_prev), 32'h00);
      check("b2b_second", 32'(v_data_last), 32'hFF);
      check("b2b_spacing", 32'(v_cyc_last - v_cyc_prev), 176);
      check("b2b_perr", 32'(rx.Parity_err), 0);
      check("b2b_ferr", 32'(rx.Frame_err), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
UART receive stage; the far-end counterpart of the transmitter FSM, consuming the serial frame it produces (start, 8 data LSB-first, parity, stop). Runs on the same 16x oversampled Baud_Clk. Synchronises the line, validates the start bit at mid-bit, samples each bit at its centre, checks parity and stop, then presents a parallel byte with a one-cycle valid strobe and error flags.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first
OVERSAMPLE, 16, Baud_Clk cycles per bit; must be even and >= 4
PARITY_EN, 1, 1 = parity bit present and checked; 0 = frame goes data -> stop
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
Baud_Clk  input  1  oversampling clock, 16x bit rate; all logic on rising edge
Reset  input  1  synchronous, active-high; one clock, no other clocks
Rx_in  input  1  asynchronous serial line, idle high
Rx_data  output  DATA_BITS  last received byte, held until next frame completes
Rx_valid  output  1  one-cycle pulse: Rx_data/Parity_err/Frame_err updated
Parity_err  output  1  parity mismatch on last frame; held until next Rx_valid
Frame_err  output  1  stop bit sampled low on last frame; held until next Rx_valid
Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, high): state IDLE, Rx_data=0, Rx_valid=0, Parity_err=0, Frame_err=0, Busy=0, tick counter=0, bit counter=0, sync flops=1, previous-line register=1. Reset mid-frame abandons the frame with no Rx_valid.
- Rx_in passes a 2-flop synchroniser (reset value 1); all logic uses the synchronised line rxs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: falling edge on rxs (previous 1, current 0) -> START, tick=0. Line held low without a prior high does not start a frame (break / stuck-low protection).
- START: tick increments each cycle; at tick==OVERSAMPLE/2-1 sample rxs: 1 -> glitch, return to IDLE, no outputs change; 0 -> DATA, tick=0, bit=0.
- DATA: at tick==OVERSAMPLE-1 shift rxs into shift register MSB end (LSB-first reception), tick=0, bit++; after DATA_BITS samples -> PARITY (PARITY_EN=1) or STOP.
- PARITY: at tick==OVERSAMPLE-1 sample parity bit; mismatch = XOR(data bits, parity bit) != PARITY_ODD; store; -> STOP, tick=0.
- STOP: at tick==OVERSAMPLE-1 sample; Frame_err = ~rxs; Rx_data = shift register; Parity_err = stored mismatch (0 if PARITY_EN=0); Rx_valid=1 the following cycle for exactly one cycle; -> IDLE.
- Data/flags update even when errors are flagged; erroneous frames are still strobed.
- Latency: Rx_valid rises 172 +/-2 Baud_Clk cycles after the Rx_in falling edge of the start bit (defaults).
- Back-to-back frames: new start edge accepted from IDLE on the cycle after STOP completes; no minimum idle gap beyond the stop bit's second half.
- Tick counter width ceil(log2(OVERSAMPLE)); bit counter width ceil(log2(DATA_BITS+1)); no wrap occurs outside the compare points above.
- Rx_in change during mid-bit sampling is resolved by synchroniser; no metastability protection beyond 2 flops required.

Test Plan:
- Frame 0xA5, even parity bit 0, stop 1, 16 cycles/bit -> Rx_data=0xA5, Rx_valid one cycle high, Parity_err=0, Frame_err=0, Busy low afterwards.
- Frame 0x3C sent with parity bit 1 (wrong for even) -> Rx_data=0x3C, Parity_err=1, Frame_err=0; next clean frame 0x01 parity 1 clears Parity_err.
- Frame 0xFF with stop bit 0, then line held low 40 bit times -> Rx_data=0xFF, Frame_err=1; no second Rx_valid until line returns high and falls again.
- Rx_in low for 4 cycles then high -> return to IDLE, no Rx_valid, Rx_data unchanged, Busy high only during glitch window.
- Reset asserted 1 cycle at bit 3 of frame 0x55 -> all outputs 0, state IDLE; following frame 0x81 received correctly.
- Back-to-back 0x00 and 0xFF with no idle gap, PARITY_EN=1 -> two Rx_valid pulses 176 cycles apart, data 0x00 then 0xFF, no errors.
